// File: rtl/icache_controller.sv
// Direct-mapped instruction cache controller: 8 lines x 16 bytes over a 1 KiB space.
// A miss latches the block address, fetches a whole line from memory, then replays the fetch.
module icache_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic         read,
  input  logic [31:0]  pc,
  output logic [31:0]  instruction,
  output logic         busywait,
  output logic         mem_read,
  output logic [5:0]   mem_address,
  input  logic [127:0] mem_readdata,
  input  logic         mem_busywait
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_READ = 2'd1,
    S_UPDATE   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    valid_q, valid_d;
  logic [5:0]    miss_addr_q, miss_addr_d;
  logic [127:0]  data_q [8];
  logic [127:0]  data_d [8];
  logic [2:0]    tag_q  [8];
  logic [2:0]    tag_d  [8];

  logic [2:0]    pc_tag;
  logic [2:0]    pc_index;
  logic [1:0]    pc_offset;
  logic          hit;
  logic          fill;
  logic [127:0]  line;

  assign pc_tag    = pc[9:7];
  assign pc_index  = pc[6:4];
  assign pc_offset = pc[3:2];

  assign hit  = read && valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign line = data_q[pc_index];
  assign instruction = line[32*pc_offset +: 32];

  assign mem_read    = (state_q == S_MEM_READ);
  assign mem_address = miss_addr_q;

  // A fill edge that coincides with reset must not leave a valid line behind.
  assign fill = (state_q == S_MEM_READ) && !mem_busywait && reset;

  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    valid_d     = valid_q;
    busywait    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (read && !hit) begin
          busywait    = 1'b1;
          miss_addr_d = pc[9:4];
          state_d     = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        busywait = 1'b1;
        if (!mem_busywait) begin
          valid_d[miss_addr_q[2:0]] = 1'b1;
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        busywait = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (!reset) begin
      busywait = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      data_d[i] = data_q[i];
      tag_d[i]  = tag_q[i];
    end
    if (fill) begin
      data_d[miss_addr_q[2:0]] = mem_readdata;
      tag_d[miss_addr_q[2:0]]  = miss_addr_q[5:3];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      miss_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      miss_addr_q <= miss_addr_d;
    end
  end

  // Line storage is left unreset; the valid bits alone decide whether it is usable.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      data_q[i] <= data_d[i];
      tag_q[i]  <= tag_d[i];
    end
  end

endmodule
